// File: rtl/onehot_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : onehot_rr_arbiter_pkg
// Brief  : Shared FSM encoding and default sizing for the round-robin arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package onehot_rr_arbiter_pkg;

  localparam int c_REQ_NUM = 8;
  localparam int c_IDX_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_rr_arbiter_encoder.sv
`default_nettype none
// ============================================================================
// Module : onehot_encoder
// Brief  : One-hot to binary encoder built only from OR reductions.
// Rev    : 1.0 - initial release
// ============================================================================
module onehot_encoder #(
  parameter int INPUT_W  = 8,
  parameter int OUTPUT_W = 3
) (
  input  logic [INPUT_W-1:0]  i_onehot,
  output logic [OUTPUT_W-1:0] o_idx
);

  // Input 0 encodes to all-zero, so it never feeds any OR term.
  logic w_unused;
  assign w_unused = i_onehot[0];

  for (genvar b = 0; b < OUTPUT_W; b++) begin : g_bit
    logic [INPUT_W-1:0] w_term;
    for (genvar k = 0; k < INPUT_W; k++) begin : g_in
      if (((k >> b) & 1) == 1) begin : g_or
        assign w_term[k] = i_onehot[k];
      end else begin : g_zero
        assign w_term[k] = 1'b0;
      end
    end
    assign o_idx[b] = |w_term;
  end

endmodule
`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : onehot_rr_arbiter
// Brief  : Round-robin arbiter with registered one-hot grant and
//          back-to-back re-arbitration on handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int REQ_NUM = c_REQ_NUM,
  parameter int IDX_W   = c_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_i,
  input  logic               gnt_rdy_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  localparam logic [2*REQ_NUM-1:0] c_DBL_ONE = {{(2*REQ_NUM-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic [IDX_W-1:0]     w_arb_ptr;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic [REQ_NUM-1:0]   r_gnt;
  logic [REQ_NUM-1:0]   w_gnt_nxt;
  logic [REQ_NUM-1:0]   w_mask;
  logic [REQ_NUM-1:0]   w_pick;
  logic [2*REQ_NUM-1:0] w_dbl;
  logic [2*REQ_NUM-1:0] w_dbl_first;
  logic                 w_any_req;
  logic                 w_cur_req;
  logic                 w_hs;

  onehot_encoder #(
    .INPUT_W  (REQ_NUM),
    .OUTPUT_W (IDX_W)
  ) u_enc (
    .i_onehot (r_gnt),
    .o_idx    (w_gnt_idx)
  );

  assign w_any_req = |req_i;
  assign w_cur_req = |(req_i & r_gnt);
  assign w_hs      = (r_state == ST_GRANT) && gnt_rdy_i && w_cur_req;
  assign w_ptr_inc = (w_gnt_idx == IDX_W'(REQ_NUM - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
  // A handshake re-arbitrates with the advanced pointer in the same cycle.
  assign w_arb_ptr = w_hs ? w_ptr_inc : r_ptr;

  for (genvar k = 0; k < REQ_NUM; k++) begin : g_mask
    assign w_mask[k] = (IDX_W'(k) >= w_arb_ptr);
  end

  // Lower half holds requests at/after the pointer; upper half is the wrap fallback.
  assign w_dbl       = {req_i, req_i & w_mask};
  assign w_dbl_first = w_dbl & (~w_dbl + c_DBL_ONE);
  assign w_pick      = w_dbl_first[REQ_NUM-1:0] | w_dbl_first[2*REQ_NUM-1:REQ_NUM];

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_cur_req) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (gnt_rdy_i) begin
          w_ptr_nxt = w_ptr_inc;
          w_gnt_nxt = w_pick;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = w_gnt_idx;
  assign gnt_vld_o = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_onehot_rr_arbiter
// Brief  : Directed scoreboard bench for an 8-way and a 5-way arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, rst5;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       rdy8, rdy5;
  logic [7:0] gnt8;
  logic [4:0] gnt5;
  logic [2:0] idx8, idx5;
  logic       vld8, vld5;
  logic       chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.REQ_NUM(8), .IDX_W(3)) u_dut8 (
    .clk       (clk),
    .rst       (rst8),
    .req_i     (req8),
    .gnt_rdy_i (rdy8),
    .gnt_o     (gnt8),
    .gnt_idx_o (idx8),
    .gnt_vld_o (vld8)
  );

  onehot_rr_arbiter #(.REQ_NUM(5), .IDX_W(3)) u_dut5 (
    .clk       (clk),
    .rst       (rst5),
    .req_i     (req5),
    .gnt_rdy_i (rdy5),
    .gnt_o     (gnt5),
    .gnt_idx_o (idx5),
    .gnt_vld_o (vld5)
  );

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    idx_of = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) idx_of = 3'(i);
  endfunction

  task automatic compare(input string tag, input logic [7:0] g, input logic [2:0] ix,
                         input logic v, input logic [7:0] eg);
    checks++;
    assert (g === eg) else begin
      errors++;
      $error("FAIL %s gnt_o got %b expected %b", tag, g, eg);
    end
    checks++;
    assert (ix === idx_of(eg)) else begin
      errors++;
      $error("FAIL %s gnt_idx_o got %0d expected %0d", tag, ix, idx_of(eg));
    end
    checks++;
    assert (v === (|eg)) else begin
      errors++;
      $error("FAIL %s gnt_vld_o got %b expected %b", tag, v, |eg);
    end
  endtask

  task automatic step8(input string tag, input logic [7:0] req, input logic rdy,
                       input logic rs, input logic [7:0] eg);
    exp_t e;
    req8 = req; rdy8 = rdy; rst8 = rs;
    e.tag = tag; e.gnt = eg;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    compare(e.tag, gnt8, idx8, vld8, e.gnt);
  endtask

  task automatic step5(input string tag, input logic [4:0] req, input logic rdy,
                       input logic rs, input logic [4:0] eg);
    exp_t e;
    req5 = req; rdy5 = rdy; rst5 = rs;
    e.tag = tag; e.gnt = {3'b000, eg};
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    compare(e.tag, {3'b000, gnt5}, idx5, vld5, e.gnt);
  endtask

  // Structural invariants on both instances every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      assert ($countones(gnt8) <= 1 && idx8 === idx_of(gnt8) && vld8 === (|gnt8)) else begin
        errors++;
        $error("FAIL inv8 gnt=%b idx=%0d vld=%b expected onehot/consistent", gnt8, idx8, vld8);
      end
      checks++;
      assert ($countones(gnt5) <= 1 && idx5 === idx_of({3'b000, gnt5}) && vld5 === (|gnt5)
              && idx5 < 3'd5) else begin
        errors++;
        $error("FAIL inv5 gnt=%b idx=%0d vld=%b expected onehot/consistent/idx<5", gnt5, idx5, vld5);
      end
    end
  end

  initial begin
    rst8 = 1'b1; rst5 = 1'b1;
    req8 = '0;   req5 = '0;
    rdy8 = 1'b0; rdy5 = 1'b0;

    step8("reset", 8'h00, 1'b0, 1'b1, 8'h00);
    chk_en = 1'b1;

    for (int i = 0; i < 5; i++) step8("idle_zero", 8'h00, 1'b1, 1'b0, 8'h00);

    step8("rr_0a", 8'h85, 1'b1, 1'b0, 8'h01);
    step8("rr_2a", 8'h85, 1'b1, 1'b0, 8'h04);
    step8("rr_7a", 8'h85, 1'b1, 1'b0, 8'h80);
    step8("rr_0b", 8'h85, 1'b1, 1'b0, 8'h01);
    step8("rr_2b", 8'h85, 1'b1, 1'b0, 8'h04);
    step8("rr_7b", 8'h85, 1'b1, 1'b0, 8'h80);
    step8("solo_regrant", 8'h80, 1'b1, 1'b0, 8'h80);
    step8("abort_rdy", 8'h00, 1'b1, 1'b0, 8'h00);

    step8("hold_a", 8'h02, 1'b0, 1'b0, 8'h02);
    step8("hold_b", 8'h02, 1'b0, 1'b0, 8'h02);
    step8("hold_c", 8'h22, 1'b0, 1'b0, 8'h02);
    step8("hold_d", 8'h22, 1'b0, 1'b0, 8'h02);
    step8("next5", 8'h22, 1'b1, 1'b0, 8'h20);
    step8("regrant5", 8'h20, 1'b1, 1'b0, 8'h20);
    step8("abort5", 8'h00, 1'b0, 1'b0, 8'h00);

    step8("grant3", 8'h08, 1'b0, 1'b0, 8'h08);
    step8("abort3", 8'h00, 1'b0, 1'b0, 8'h00);
    step8("regrant3", 8'h18, 1'b0, 1'b0, 8'h08);

    step8("hs3", 8'h88, 1'b1, 1'b0, 8'h80);
    step8("wrap", 8'h81, 1'b1, 1'b0, 8'h01);
    step8("hs0", 8'h81, 1'b1, 1'b0, 8'h80);
    step8("rst_mid", 8'hFF, 1'b1, 1'b1, 8'h00);
    step8("post_rst", 8'hFF, 1'b0, 1'b0, 8'h01);
    step8("hs_after", 8'hFF, 1'b1, 1'b0, 8'h02);
    step8("final_abort", 8'h00, 1'b0, 1'b0, 8'h00);

    step5("rst5", 5'h00, 1'b0, 1'b1, 5'h00);
    step5("n5_0", 5'h1F, 1'b1, 1'b0, 5'b00001);
    step5("n5_1", 5'h1F, 1'b1, 1'b0, 5'b00010);
    step5("n5_2", 5'h1F, 1'b1, 1'b0, 5'b00100);
    step5("n5_3", 5'h1F, 1'b1, 1'b0, 5'b01000);
    step5("n5_4", 5'h1F, 1'b1, 1'b0, 5'b10000);
    step5("n5_wrap", 5'h1F, 1'b1, 1'b0, 5'b00001);
    step5("n5_abort", 5'h00, 1'b1, 1'b0, 5'b00000);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
